// File: rtl/spi_sibal_s00_axi_slave.sv
// AXI4-Lite register slave for the SPI core: four 32-bit registers, a start strobe and OKAY responses.
// Optional build macro SPI_SIBAL_RX_READBACK_EN turns reg3 into a read-only RXDATA capture of spi_rxdata.
module spi_sibal_s00_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   spi_ctrl,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   spi_txdata,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   spi_cfg,
    output logic                            spi_start,
    input  logic                            spi_done,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   spi_rxdata
);

    localparam int NUM_LANES = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        W_IDLE   = 2'b00,
        W_ACCEPT = 2'b01,
        W_RESP   = 2'b10
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'b00,
        R_ACCEPT = 2'b01,
        R_DATA   = 2'b10
    } rd_state_t;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic [1:0]                    wr_sel;
    logic [1:0]                    rd_sel;
    logic                          wr_hs;
    logic                          rd_hs;
    logic                          wr_writable;

    assign s00_axi_awready = (wr_state == W_ACCEPT);
    assign s00_axi_wready  = (wr_state == W_ACCEPT);
    assign s00_axi_bvalid  = (wr_state == W_RESP);
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = (rd_state == R_ACCEPT);
    assign s00_axi_rvalid  = (rd_state == R_DATA);
    assign s00_axi_rresp   = 2'b00;

    assign wr_hs  = s00_axi_awready && s00_axi_awvalid && s00_axi_wready && s00_axi_wvalid;
    assign rd_hs  = s00_axi_arready && s00_axi_arvalid;
    assign wr_sel = s00_axi_awaddr[3:2];
    assign rd_sel = s00_axi_araddr[3:2];

`ifdef SPI_SIBAL_RX_READBACK_EN
    assign wr_writable = (wr_sel != 2'd3);
`else
    assign wr_writable = 1'b1;
`endif

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    // NOTE: next-state is assigned a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE:   if (s00_axi_awvalid && s00_axi_wvalid) wr_state_nxt = W_ACCEPT;
            W_ACCEPT: wr_state_nxt = wr_hs ? W_RESP : W_IDLE;
            W_RESP:   if (s00_axi_bready) wr_state_nxt = W_IDLE;
            default:  wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:   if (s00_axi_arvalid) rd_state_nxt = R_ACCEPT;
            R_ACCEPT: rd_state_nxt = rd_hs ? R_DATA : R_IDLE;
            R_DATA:   if (s00_axi_rready) rd_state_nxt = R_IDLE;
            default:  rd_state_nxt = R_IDLE;
        endcase
    end

    // NOTE: the register file is only four words, so it is reset like ordinary flops rather than left as RAM.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            for (int r = 0; r < 4; r++) regs[r] <= '0;
        end else begin
            if (wr_hs && wr_writable) begin
                for (int b = 0; b < NUM_LANES; b++) begin
                    if (s00_axi_wstrb[b]) regs[wr_sel][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                end
            end
`ifdef SPI_SIBAL_RX_READBACK_EN
            if (spi_done) regs[3] <= spi_rxdata;
`endif
        end
    end

    // Start fires alongside bvalid when CTRL bit0 is written as 1; the bit itself is left for software to clear.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            spi_start <= 1'b0;
        end else begin
            spi_start <= wr_hs && (wr_sel == 2'd0) && s00_axi_wstrb[0] && s00_axi_wdata[0];
        end
    end

    // Read data is captured at the handshake edge, so a same-cycle write commit is not visible.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            s00_axi_rdata <= '0;
        end else if (rd_hs) begin
            s00_axi_rdata <= regs[rd_sel];
        end
    end

    assign spi_ctrl   = regs[0];
    assign spi_txdata = regs[1];
    assign spi_cfg    = regs[2];

`ifdef SPI_SIBAL_RX_READBACK_EN
    logic unused_inputs;
    assign unused_inputs = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
`else
    logic unused_inputs;
    assign unused_inputs = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0], spi_done, spi_rxdata};
`endif

endmodule

// File: doc/spi_sibal_s00_axi_slave.md
Name: spi_sibal_s00_axi_slave

Overview:
AXI4-Lite responder (slave end) for the SPI core's S00_AXI register port; it is the target the master VIP agent drives in the BFM design. It holds four 32-bit registers at word offsets 0x0/0x4/0x8/0xC, exports their values and a one-cycle start pulse to the SPI engine, and returns OKAY responses. One outstanding write and one outstanding read at a time; the read and write channels run independently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
s00_axi_aclk  in  1  single clock.
s00_axi_reset  in  1  synchronous, active-high reset.
s00_axi_awaddr  in  4  write address.
s00_axi_awprot  in  3  ignored.
s00_axi_awvalid  in  1  write address valid.
s00_axi_awready  out  1  write address ready.
s00_axi_wdata  in  32  write data.
s00_axi_wstrb  in  4  byte strobes.
s00_axi_wvalid  in  1  write data valid.
s00_axi_wready  out  1  write data ready.
s00_axi_bresp  out  2  write response; always 2'b00.
s00_axi_bvalid  out  1  write response valid.
s00_axi_bready  in  1  write response ready.
s00_axi_araddr  in  4  read address.
s00_axi_arprot  in  3  ignored.
s00_axi_arvalid  in  1  read address valid.
s00_axi_arready  out  1  read address ready.
s00_axi_rdata  out  32  read data.
s00_axi_rresp  out  2  read response; always 2'b00.
s00_axi_rvalid  out  1  read data valid.
s00_axi_rready  in  1  read data ready.
spi_ctrl  out  32  register 0 (CTRL) contents.
spi_txdata  out  32  register 1 (TXDATA) contents.
spi_cfg  out  32  register 2 (CONFIG) contents.
spi_start  out  1  one-cycle start strobe.
spi_done  in  1  one-cycle pulse from the SPI engine at end of transfer.
spi_rxdata  in  32  received word; valid while spi_done=1.

Behaviour:
- Reset: all registers, awready, wready, bvalid, arready, rvalid, spi_start = 0; rdata = 0; bresp = rresp = 2'b00. A reset mid-transaction drops any pending valid; the master must reissue.
- Write accept:
  - awready and wready are registered and assert together for exactly one cycle.
  - They assert in the cycle after awvalid&&wvalid is sampled high while awready=0 and bvalid=0.
  - If only one of awvalid/wvalid is high, wait; never accept one channel alone.
- Write commit: on the handshake cycle (awready&&awvalid&&wready&&wvalid), update reg[awaddr[3:2]] byte-wise per wstrb; lanes with wstrb=0 are unchanged.
- Write response: bvalid=1 on the cycle after the handshake, held until bready. Clear on the bvalid&&bready cycle. No new write is accepted while bvalid=1.
- spi_start: asserted for one cycle, concurrent with bvalid rising, when the committed write targeted reg0 with wstrb[0]=1 and wdata[0]=1. reg0 bit0 itself stays as written (software clears it).
- Read accept: arready asserts for one cycle, in the cycle after arvalid is sampled high while arready=0 and rvalid=0. araddr is captured on the handshake.
- Read data: rvalid=1 with rdata = selected register on the cycle after the handshake; rdata is stable while rvalid=1, held until rready.
  - Back-to-back reads: the next arready can assert no earlier than the cycle after the rvalid&&rready cycle.
- Simultaneous read and write to the same register: the read handshake samples the register value before that cycle's write commit (old data).
- spi_done is ignored unless the optional feature is compiled in.
- Outputs spi_ctrl, spi_txdata and spi_cfg are direct register outputs; they update the cycle after the commit.

Optional Feature:
SPI_SIBAL_RX_READBACK_EN
- Defined: reg3 becomes RXDATA, read-only.
  - AXI writes to 0xC are acknowledged with bvalid/OKAY but do not modify reg3.
  - reg3 loads spi_rxdata on any cycle with spi_done=1.
  - A read handshake in the same cycle as spi_done returns the old value.
- Undefined: reg3 is a plain R/W register like reg0–reg2; spi_done and spi_rxdata are unused.

Test Plan:
- Sequential write 0x1,0x2,0x3,0x4 to 0x0/0x4/0x8/0xC, then read all back -> reads return 0x1..0x4 with OKAY; spi_start pulses once (after the 0x0 write, data bit0=1).
- Write 0xAABBCCDD to 0x4 with wstrb=4'b0101 over a prior value of 0 -> read 0x4 = 0x00BB00DD; spi_txdata = 0x00BB00DD.
- awvalid high 5 cycles before wvalid -> awready/wready assert together only after wvalid rises; exactly one commit occurs.
- bready held low 10 cycles -> bvalid stays 1 and a second write is not accepted until the B handshake; rready low -> rdata held constant.
- Assert reset while bvalid=1 -> bvalid=0 the next cycle and all registers read 0.
- With SPI_SIBAL_RX_READBACK_EN: pulse spi_done with spi_rxdata=0x5A5A1234, then write 0xFFFFFFFF to 0xC -> read 0xC = 0x5A5A1234 and bresp = OKAY.
